// File: rtl/bdd_pkg.sv
// Shared definitions for the decision-tree node loader.
//   state_t      : loader FSM states
//   SYNC_BYTE_DEFAULT : default frame start marker
//   bytes_for()  : number of stream bytes needed to carry a word of a given width
package bdd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      R1,
      R2,
      WRITE,
      CHK,
      DONE,
      ERR
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   function automatic int bytes_for(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/bdd_byte_assembler.sv
// Big-endian shift-in register for one RAM word, with a byte counter.
// Surplus MSBs of the first byte fall off the top of the register.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart assembly (counter and register to zero)
//   shift     : byte_in is consumed this cycle
//   byte_in   : stream byte
//   word      : assembled word, including byte_in when shift is high
//   last      : the next shifted byte completes the word
module bdd_byte_assembler
   import bdd_pkg::*;
#(
   parameter int WIDTH = 34
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             shift,
   input  logic [7:0]       byte_in,
   output logic [WIDTH-1:0] word,
   output logic             last
);

   localparam int NBYTES = bytes_for(WIDTH);
   localparam int CW     = $clog2(NBYTES + 1);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] shifted;
   logic [CW-1:0]    cnt;

   assign shifted = {sr[WIDTH-9:0], byte_in};
   // Bypass the incoming byte so the owner can capture a complete word
   // on the same cycle its final byte arrives.
   assign word    = shift ? shifted : sr;
   assign last    = (cnt == CW'(NBYTES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (clear) begin
         sr  <= '0;
         cnt <= '0;
      end else if (shift) begin
         sr  <= shifted;
         cnt <= last ? '0 : cnt + CW'(1);
      end
   end

endmodule

// File: rtl/bdd_node_loader.sv
// Decision-tree node memory loader: parses a host byte stream
// (SYNC, COUNT, COUNT x {RAM1 bytes, RAM2 bytes}, CHK) and writes the
// assembled words into RAM1/RAM2 at addresses 0..COUNT-1.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for SYNC, other bytes dropped
// COUNT | receive node count N (0 or > DEPTH is a format error)
// R1    | shift RAM1 word bytes
// R2    | shift RAM2 word bytes
// WRITE | one-cycle write of both words at the current node index
// CHK   | receive checksum byte, compare with running XOR
// DONE  | one-cycle done pulse
// ERR   | one-cycle error entry, error flag stays set until next SYNC
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_data/valid   : stream byte and its valid; in_ready is the accept
//   mem_addr        : shared RAM write address
//   ram1/2_data_out : RAM write data
//   we1, we2        : RAM write enables
//   busy            : frame in progress
//   done            : one-cycle pulse on a frame loaded with good checksum
//   error           : sticky frame error
//
// All outputs are registered from the next-state decode so that they
// read 0 while reset is held and still line up with their state.
module bdd_node_loader
   import bdd_pkg::*;
#(
   parameter int         RAM1_DATA_WIDTH = 34,
   parameter int         RAM2_DATA_WIDTH = 18,
   parameter int         ADDR_WIDTH      = 5,
   parameter int         DEPTH           = 32,
   parameter logic [7:0] SYNC_BYTE       = SYNC_BYTE_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [ADDR_WIDTH-1:0]      mem_addr,
   output logic [RAM1_DATA_WIDTH-1:0] ram1_data_out,
   output logic [RAM2_DATA_WIDTH-1:0] ram2_data_out,
   output logic                       we1,
   output logic                       we2,
   output logic                       busy,
   output logic                       done,
   output logic                       error
);

   // One extra bit so the index can represent N = DEPTH.
   localparam int CW = ADDR_WIDTH + 1;

   state_t state, state_next;

   logic                       accept;
   logic                       sync_seen;
   logic                       count_bad;
   logic                       asm1_shift, asm2_shift;
   logic                       asm1_last, asm2_last;
   logic [RAM1_DATA_WIDTH-1:0] asm1_word;
   logic [RAM2_DATA_WIDTH-1:0] asm2_word;
   logic [CW-1:0]              idx;
   logic [CW-1:0]              n;
   logic [7:0]                 chk_acc;

   assign accept     = in_valid & in_ready;
   assign sync_seen  = (state == IDLE) && accept && (in_data == SYNC_BYTE);
   assign count_bad  = (in_data == 8'd0) || (int'(in_data) > DEPTH);
   assign asm1_shift = (state == R1) && accept;
   assign asm2_shift = (state == R2) && accept;

   bdd_byte_assembler #(.WIDTH(RAM1_DATA_WIDTH)) u_asm1 (
      .clk     (clk),
      .rst     (rst),
      .clear   (sync_seen),
      .shift   (asm1_shift),
      .byte_in (in_data),
      .word    (asm1_word),
      .last    (asm1_last)
   );

   bdd_byte_assembler #(.WIDTH(RAM2_DATA_WIDTH)) u_asm2 (
      .clk     (clk),
      .rst     (rst),
      .clear   (sync_seen),
      .shift   (asm2_shift),
      .byte_in (in_data),
      .word    (asm2_word),
      .last    (asm2_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:  if (sync_seen) state_next = COUNT;
         COUNT: if (accept) state_next = count_bad ? ERR : R1;
         R1:    if (accept && asm1_last) state_next = R2;
         R2:    if (accept && asm2_last) state_next = WRITE;
         WRITE: state_next = (idx + CW'(1) == n) ? CHK : R1;
         CHK:   if (accept) state_next = (in_data == chk_acc) ? DONE : ERR;
         DONE:  state_next = IDLE;
         ERR:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_ready      <= 1'b0;
         busy          <= 1'b0;
         we1           <= 1'b0;
         we2           <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         mem_addr      <= '0;
         ram1_data_out <= '0;
         ram2_data_out <= '0;
         idx           <= '0;
         n             <= '0;
         chk_acc       <= '0;
      end else begin
         in_ready <= (state_next == IDLE) || (state_next == COUNT) ||
                     (state_next == R1)   || (state_next == R2)    ||
                     (state_next == CHK);
         busy     <= (state_next != IDLE);
         we1      <= (state_next == WRITE);
         we2      <= (state_next == WRITE);
         done     <= (state_next == DONE);

         if (sync_seen)                error <= 1'b0;
         else if (state_next == ERR)   error <= 1'b1;

         if (state_next == WRITE) begin
            mem_addr      <= idx[ADDR_WIDTH-1:0];
            ram1_data_out <= asm1_word;
            ram2_data_out <= asm2_word;
         end

         if (state == COUNT && accept) begin
            idx <= '0;
            if (!count_bad) n <= CW'(in_data);
         end else if (state == WRITE) begin
            idx <= idx + CW'(1);
         end

         if (sync_seen)
            chk_acc <= '0;
         else if (accept && (state == COUNT || state == R1 || state == R2))
            chk_acc <= chk_acc ^ in_data;
      end
   end

endmodule

// File: tb/tb_bdd_node_loader.sv
// Self-checking bench for bdd_node_loader: frames are built from random node
// words by a byte-level model, driven with random valid gaps, and the RAM
// write port activity is compared against the model's node list.
module tb_bdd_node_loader;

   localparam int W1    = 34;
   localparam int W2    = 18;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] mem_addr;
   logic [W1-1:0] ram1_data_out;
   logic [W2-1:0] ram2_data_out;
   logic          we1, we2, busy, done, error;

   bdd_node_loader dut (
      .clk           (clk),
      .rst           (rst),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .mem_addr      (mem_addr),
      .ram1_data_out (ram1_data_out),
      .ram2_data_out (ram2_data_out),
      .we1           (we1),
      .we2           (we2),
      .busy          (busy),
      .done          (done),
      .error         (error)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic [W1-1:0] d1;
      logic [W2-1:0] d2;
      int            cyc;
   } wr_t;

   wr_t wq[$];
   int  done_cnt;
   int  done_cyc;
   int  ready_on_write;
   int  busy_seen;

   always @(negedge clk) begin
      if (we1 || we2) begin
         wq.push_back('{mem_addr, ram1_data_out, ram2_data_out, cycle});
         if (in_ready || (we1 !== we2)) ready_on_write++;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cycle;
      end
      if (busy) busy_seen++;
   end

   // Reference model: node words and the byte frame that carries them.
   logic [W1-1:0] m1[DEPTH];
   logic [W2-1:0] m2[DEPTH];
   logic [7:0]    fq[$];

   task automatic make_frame(input int nn, input bit bad);
      logic [39:0] w1;
      logic [23:0] w2;
      logic [7:0]  x;
      fq.delete();
      fq.push_back(8'hA5);
      fq.push_back(8'(nn));
      x = 8'(nn);
      for (int i = 0; i < nn; i++) begin
         m1[i] = W1'({$urandom, $urandom});
         m2[i] = W2'($urandom);
         // random junk in the surplus MSBs must be discarded by the loader
         w1 = {6'($urandom), m1[i]};
         w2 = {6'($urandom), m2[i]};
         for (int k = 4; k >= 0; k--) begin
            fq.push_back(w1[k*8 +: 8]);
            x ^= w1[k*8 +: 8];
         end
         for (int k = 2; k >= 0; k--) begin
            fq.push_back(w2[k*8 +: 8]);
            x ^= w2[k*8 +: 8];
         end
      end
      fq.push_back(bad ? ~x : x);
   endtask

   task automatic clear_mon();
      wq.delete();
      done_cnt       = 0;
      done_cyc       = 0;
      ready_on_write = 0;
      busy_seen      = 0;
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte is taken.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(0, gap)) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready) begin
         @(posedge clk);
         #1;
         t++;
         if (t > 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout byte=%0h never accepted", b);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic send_frame(input int gap);
      foreach (fq[i]) send_byte(fq[i], gap);
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #12;
      checks++;
      if ({in_ready, busy, we1, we2, done, error} !== 6'b0 ||
          mem_addr !== '0 || ram1_data_out !== '0 || ram2_data_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs got ctl=%b addr=%0h d1=%0h d2=%0h exp all 0",
                  {in_ready, busy, we1, we2, done, error}, mem_addr, ram1_data_out, ram2_data_out);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got in_ready=%b busy=%b exp 1 0", in_ready, busy);
      end
   endtask

   task automatic test_single_node();
      clear_mon();
      fq = '{8'hA5, 8'h01, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'h23, 8'h45, 8'h6D};
      send_frame(0);
      settle();
      checks++;
      if (wq.size() != 1) begin
         failures++;
         $display("FAIL single_writes got=%0d exp=1", wq.size());
      end else begin
         checks++;
         if (wq[0].addr !== 5'd0 || wq[0].d1 !== 34'h3_1234_5678 || wq[0].d2 !== 18'h1_2345) begin
            failures++;
            $display("FAIL single_data got addr=%0h d1=%0h d2=%0h exp 0 312345678 12345",
                     wq[0].addr, wq[0].d1, wq[0].d2);
         end
         checks++;
         if (done_cnt != 1 || done_cyc - wq[0].cyc != 2) begin
            failures++;
            $display("FAIL single_done got pulses=%0d delay=%0d exp 1 2", done_cnt, done_cyc - wq[0].cyc);
         end
      end
      checks++;
      if (error !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL single_flags got error=%b busy=%b exp 0 0", error, busy);
      end
   endtask

   task automatic test_bad_checksum();
      clear_mon();
      fq = '{8'hA5, 8'h01, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'h23, 8'h45, 8'h6C};
      send_frame(1);
      settle();
      checks++;
      if (wq.size() != 1 || done_cnt != 0 || error !== 1'b1) begin
         failures++;
         $display("FAIL badchk got writes=%0d done=%0d error=%b exp 1 0 1", wq.size(), done_cnt, error);
      end
      send_byte(8'hA5, 0);
      checks++;
      if (error !== 1'b0) begin
         failures++;
         $display("FAIL badchk_clear got error=%b exp 0", error);
      end
      fq = '{8'h01, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'h23, 8'h45, 8'h6D};
      send_frame(0);
      settle();
      checks++;
      if (done_cnt != 1 || wq.size() != 2) begin
         failures++;
         $display("FAIL badchk_recover got done=%0d writes=%0d exp 1 2", done_cnt, wq.size());
      end
   endtask

   task automatic test_bad_count();
      logic [7:0] bad_n[2];
      bad_n[0] = 8'h00;
      bad_n[1] = 8'h21;
      for (int j = 0; j < 2; j++) begin
         clear_mon();
         send_byte(8'hA5, 0);
         send_byte(bad_n[j], 0);
         settle();
         checks++;
         if (wq.size() != 0 || error !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL badcount n=%0h got writes=%0d error=%b busy=%b exp 0 1 0",
                     bad_n[j], wq.size(), error, busy);
         end
         busy_seen = 0;
         for (int k = 0; k < 12; k++) send_byte(8'(k * 7 + 1), 1);
         settle();
         checks++;
         if (busy_seen != 0 || wq.size() != 0) begin
            failures++;
            $display("FAIL badcount_ignore got busy_cycles=%0d writes=%0d exp 0 0", busy_seen, wq.size());
         end
      end
   endtask

   task automatic test_garbage();
      clear_mon();
      send_byte(8'h00, 0);
      send_byte(8'hFF, 1);
      send_byte(8'h5A, 2);
      checks++;
      if (busy_seen != 0) begin
         failures++;
         $display("FAIL garbage_busy got busy_cycles=%0d exp 0", busy_seen);
      end
      make_frame(2, 1'b0);
      send_frame(1);
      settle();
      checks++;
      if (wq.size() != 2 || done_cnt != 1 || error !== 1'b0) begin
         failures++;
         $display("FAIL garbage_frame got writes=%0d done=%0d error=%b exp 2 1 0", wq.size(), done_cnt, error);
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (wq[i].addr !== AW'(i) || wq[i].d1 !== m1[i] || wq[i].d2 !== m2[i]) begin
               failures++;
               $display("FAIL garbage_node%0d got addr=%0h d1=%0h d2=%0h exp %0h %0h %0h",
                        i, wq[i].addr, wq[i].d1, wq[i].d2, i, m1[i], m2[i]);
            end
         end
      end
   endtask

   task automatic test_full_frame();
      clear_mon();
      make_frame(DEPTH, 1'b0);
      send_frame(3);
      settle();
      checks++;
      if (wq.size() != DEPTH || done_cnt != 1 || error !== 1'b0 || ready_on_write != 0) begin
         failures++;
         $display("FAIL full_summary got writes=%0d done=%0d error=%b ready_on_write=%0d exp 32 1 0 0",
                  wq.size(), done_cnt, error, ready_on_write);
      end
      for (int i = 0; i < DEPTH && i < wq.size(); i++) begin
         checks++;
         if (wq[i].addr !== AW'(i) || wq[i].d1 !== m1[i] || wq[i].d2 !== m2[i]) begin
            failures++;
            $display("FAIL full_node%0d got addr=%0h d1=%0h d2=%0h exp %0h %0h %0h",
                     i, wq[i].addr, wq[i].d1, wq[i].d2, i, m1[i], m2[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      clear_mon();
      make_frame(3, 1'b0);
      // SYNC + COUNT + two full nodes + node 2's RAM1 bytes
      for (int i = 0; i < 23; i++) send_byte(fq[i], 1);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({in_ready, busy, we1, we2, done, error} !== 6'b0 ||
          mem_addr !== '0 || ram1_data_out !== '0 || ram2_data_out !== '0) begin
         failures++;
         $display("FAIL async_reset got ctl=%b addr=%0h exp all 0",
                  {in_ready, busy, we1, we2, done, error}, mem_addr);
      end
      checks++;
      if (wq.size() != 2) begin
         failures++;
         $display("FAIL async_partial got writes=%0d exp 2", wq.size());
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      clear_mon();
      make_frame(1, 1'b0);
      send_frame(0);
      settle();
      checks++;
      if (wq.size() != 1 || done_cnt != 1) begin
         failures++;
         $display("FAIL async_reload got writes=%0d done=%0d exp 1 1", wq.size(), done_cnt);
      end else if (wq[0].addr !== '0 || wq[0].d1 !== m1[0] || wq[0].d2 !== m2[0]) begin
         checks++;
         failures++;
         $display("FAIL async_reload_data got addr=%0h d1=%0h d2=%0h exp 0 %0h %0h",
                  wq[0].addr, wq[0].d1, wq[0].d2, m1[0], m2[0]);
      end else begin
         checks++;
      end
   endtask

   task automatic test_back_to_back();
      int nn;
      for (int f = 0; f < 3; f++) begin
         clear_mon();
         nn = $urandom_range(1, 6);
         make_frame(nn, 1'b0);
         send_frame(f);
         settle();
         checks++;
         if (wq.size() != nn || done_cnt != 1 || error !== 1'b0) begin
            failures++;
            $display("FAIL b2b_frame%0d got writes=%0d done=%0d error=%b exp %0d 1 0",
                     f, wq.size(), done_cnt, error, nn);
         end
         for (int i = 0; i < nn && i < wq.size(); i++) begin
            checks++;
            if (wq[i].addr !== AW'(i) || wq[i].d1 !== m1[i] || wq[i].d2 !== m2[i]) begin
               failures++;
               $display("FAIL b2b_frame%0d_node%0d got addr=%0h d1=%0h d2=%0h exp %0h %0h %0h",
                        f, i, wq[i].addr, wq[i].d1, wq[i].d2, i, m1[i], m2[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_node();
      test_bad_checksum();
      test_bad_count();
      test_garbage();
      test_full_frame();
      test_async_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bdd_node_loader.md
Name: bdd_node_loader

Overview:
- Writer side of the decision-tree node memories: converts a host byte stream into RAM1 (threshold/attribute) and RAM2 (child-pointer/leaf) words.
- Drives the two SRAMs' address, write-enable and data inputs, replacing direct host writes.
- Asserts busy while loading so the traversal engine holds off; reports done and checksum/format errors.

Parameters:
- RAM1_DATA_WIDTH, 34: RAM1 word width.
- RAM2_DATA_WIDTH, 18: RAM2 word width.
- ADDR_WIDTH, 5: node address width.
- DEPTH, 32: node capacity; must be ≤ 2^ADDR_WIDTH.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  byte valid
- in_ready  out  1  loader accepts byte; transfer when in_valid & in_ready
- mem_addr  out  ADDR_WIDTH  write address shared by both RAMs
- ram1_data_out  out  RAM1_DATA_WIDTH  RAM1 write data
- ram2_data_out  out  RAM2_DATA_WIDTH  RAM2 write data
- we1  out  1  RAM1 write enable
- we2  out  1  RAM2 write enable
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame loaded with good checksum
- error  out  1  sticky frame error

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, counters and checksum cleared. Reset mid-frame aborts the frame. Already-written nodes are not rolled back.
- Localparams: B1 = ceil(RAM1_DATA_WIDTH/8) = 5, B2 = ceil(RAM2_DATA_WIDTH/8) = 3.
- Frame format: SYNC, COUNT, then COUNT × (B1 RAM1 bytes, B2 RAM2 bytes), then CHK.
  - Multi-byte words are big-endian.
  - Surplus MSBs of each word's first byte are discarded.
- Checksum: CHK must equal the XOR of every byte from COUNT through the last data byte.
- Nodes are written to addresses 0..COUNT-1 in order.
- IDLE:
  - in_ready = 1, busy = 0.
  - Non-SYNC bytes are consumed and ignored.
  - SYNC → COUNT state; clears error and checksum accumulator; busy = 1.
- COUNT: accept one byte N.
  - N = 0 or N > DEPTH → ERR.
  - Otherwise store N, set node index 0 → R1.
- R1: shift bytes into the RAM1 assembly register; after B1 bytes → R2.
- R2: shift bytes into the RAM2 assembly register; after B2 bytes → WRITE.
- WRITE (exactly one cycle):
  - in_ready = 0.
  - we1 = we2 = 1; mem_addr = node index; data outputs hold the assembled words.
  - Then increment index; index = N → CHK state, else → R1.
- CHK: accept one byte.
  - Match → DONE.
  - Mismatch → ERR.
- DONE (one cycle): done = 1, in_ready = 0 → IDLE.
- ERR (one cycle): error set (sticky until next SYNC), in_ready = 0 → IDLE.
- busy is 1 in every state except IDLE.
- Outside WRITE: we1 = we2 = 0. mem_addr and data outputs hold their last values.
- No write occurs for a frame with a bad COUNT. A bad CHK still leaves the nodes written; error flags the memory contents as invalid.
- Throughput: one byte per cycle in R1/R2 with in_valid held. A node costs B1+B2+1 = 9 cycles.
- in_valid low stalls any byte-consuming state indefinitely, with no timeout.
- in_data is ignored when in_valid = 0.

Decomposition:
- Shared package (bdd_pkg):
  - state enum: IDLE, COUNT, R1, R2, WRITE, CHK, DONE, ERR
  - SYNC_BYTE default
  - B1/B2 derivation function
- Optional sub-module bdd_byte_assembler: parameterised shift-in register plus byte counter with a full flag. Instantiated twice, for RAM1 and RAM2.

Test Plan:
- Single node, no stalls: A5 01 03 12 34 56 78 01 23 45 6D → one WRITE cycle with mem_addr=0, ram1_data_out=34'h3_1234_5678, ram2_data_out=18'h1_2345, we1=we2=1; done pulses 2 cycles later; error=0.
- Bad checksum: the same frame with CHK=6C → write still occurs; error=1, no done; error clears on the next A5.
- Bad count: A5 00, and separately A5 21 (33 > 32) → ERR, no we pulses, error=1; loader returns to IDLE and ignores following bytes until A5.
- Full 32-node frame with random in_valid gaps → 32 writes at addresses 0..31 in order; in_ready=0 on each WRITE cycle; bytes are never lost or duplicated (scoreboard against a model).
- Reset asserted asynchronously after node 2's R1 bytes → all outputs 0 immediately; the subsequent valid 1-node frame loads correctly at address 0.
- Garbage bytes 00 FF 5A before A5 → ignored, busy stays 0 until SYNC; the frame then loads normally.
